// File: rtl/ot_wrr_mux_buf.sv
// N-input packet-aware weighted round-robin mux with per-input FIFOs and a 2-entry skid output.
// Define OT_WRR_MUX_STATS_EN to add the stat_pkt per-input forwarded-packet counters.
module ot_wrr_mux_buf #(
    parameter int IN_CNT     = 4,
    parameter int DATA_WIDTH = 128,
    parameter int BUF_DEPTH  = 4,
    parameter int WGT_WIDTH  = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [IN_CNT*WGT_WIDTH-1:0]  cfg_weight,
    input  logic [IN_CNT-1:0]            in_vld,
    output logic [IN_CNT-1:0]            in_rdy,
    input  logic [IN_CNT-1:0]            in_last,
    input  logic [IN_CNT*DATA_WIDTH-1:0] in_data,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic                         out_last,
    output logic [$clog2(IN_CNT)-1:0]    out_src,
    output logic [DATA_WIDTH-1:0]        out_data
`ifdef OT_WRR_MUX_STATS_EN
    ,
    output logic [IN_CNT*CNT_WIDTH-1:0]  stat_pkt
`endif
);

    localparam int SW = $clog2(IN_CNT);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int EW = DATA_WIDTH + 1;

    typedef logic [AW:0] ptr_t;

    logic [EW-1:0]        mem_q [IN_CNT][BUF_DEPTH];
    logic [EW-1:0]        mem_d [IN_CNT][BUF_DEPTH];
    ptr_t                 wp_q [IN_CNT];
    ptr_t                 wp_d [IN_CNT];
    ptr_t                 rp_q [IN_CNT];
    ptr_t                 rp_d [IN_CNT];
    logic [IN_CNT-1:0]    rdy_q, rdy_d, empty, push;
    logic [SW-1:0]        ptr_q, ptr_d, sel, own;
    logic [WGT_WIDTH-1:0] credit_q, credit_d, wsel;
    logic                 lock_q, lock_d, found, rearb, pop;
    logic [EW-1:0]        beat;
    logic                 out_vld_q, out_vld_d, out_last_q, out_last_d;
    logic [SW-1:0]        out_src_q, out_src_d, skid_src_q, skid_src_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                 skid_vld_q, skid_vld_d;
    logic [EW-1:0]        skid_q, skid_d;

    always_comb begin
        for (int i = 0; i < IN_CNT; i++) begin
            empty[i] = (wp_q[i] == rp_q[i]);
        end
    end

    // Search order starts after the owner and visits the owner last.
    always_comb begin
        int            j;
        logic [SW-1:0] jj;
        found = 1'b0;
        sel   = ptr_q;
        j     = 0;
        jj    = '0;
        for (int k = 1; k <= IN_CNT; k++) begin
            j = int'(ptr_q) + k;
            if (j >= IN_CNT) j = j - IN_CNT;
            jj = SW'(j);
            if (!found && !empty[jj]) begin
                found = 1'b1;
                sel   = jj;
            end
        end
        wsel = cfg_weight[sel*WGT_WIDTH +: WGT_WIDTH];
    end

    always_comb begin
        ptr_d    = ptr_q;
        credit_d = credit_q;
        lock_d   = lock_q;
        rearb    = !lock_q && (credit_q == '0 || empty[ptr_q]);
        if (rearb && found) begin
            ptr_d    = sel;
            credit_d = (wsel == '0) ? WGT_WIDTH'(1) : wsel;
        end
        own  = ptr_d;
        beat = mem_q[own][rp_q[own][AW-1:0]];
        pop  = !empty[own] && !skid_vld_q;
        if (pop) begin
            lock_d = !beat[EW-1];
            if (beat[EW-1]) credit_d = credit_d - 1'b1;
        end
    end

    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < IN_CNT; i++) begin
            push[i] = in_vld[i] & rdy_q[i];
            wp_d[i] = wp_q[i] + {{AW{1'b0}}, push[i]};
            rp_d[i] = rp_q[i] + {{AW{1'b0}}, (pop && own == SW'(i))};
            rdy_d[i] = ((wp_d[i] - rp_d[i]) != ptr_t'(BUF_DEPTH));
            if (push[i]) begin
                mem_d[i][wp_q[i][AW-1:0]] =
                    {in_last[i], in_data[i*DATA_WIDTH +: DATA_WIDTH]};
            end
        end
    end

    // A popped beat lands in the main register when it frees up, else in the skid.
    always_comb begin
        out_vld_d  = out_vld_q;
        out_last_d = out_last_q;
        out_src_d  = out_src_q;
        out_data_d = out_data_q;
        skid_vld_d = skid_vld_q;
        skid_d     = skid_q;
        skid_src_d = skid_src_q;
        if (!out_vld_q || out_rdy) begin
            if (skid_vld_q) begin
                out_vld_d              = 1'b1;
                {out_last_d, out_data_d} = skid_q;
                out_src_d              = skid_src_q;
                skid_vld_d             = 1'b0;
            end else if (pop) begin
                out_vld_d              = 1'b1;
                {out_last_d, out_data_d} = beat;
                out_src_d              = own;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (pop) begin
            skid_vld_d = 1'b1;
            skid_d     = beat;
            skid_src_d = own;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < IN_CNT; i++) begin
                wp_q[i] <= '0;
                rp_q[i] <= '0;
                for (int d = 0; d < BUF_DEPTH; d++) mem_q[i][d] <= '0;
            end
            rdy_q      <= '0;
            ptr_q      <= '0;
            credit_q   <= '0;
            lock_q     <= 1'b0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            out_src_q  <= '0;
            out_data_q <= '0;
            skid_vld_q <= 1'b0;
            skid_q     <= '0;
            skid_src_q <= '0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            mem_q      <= mem_d;
            rdy_q      <= rdy_d;
            ptr_q      <= ptr_d;
            credit_q   <= credit_d;
            lock_q     <= lock_d;
            out_vld_q  <= out_vld_d;
            out_last_q <= out_last_d;
            out_src_q  <= out_src_d;
            out_data_q <= out_data_d;
            skid_vld_q <= skid_vld_d;
            skid_q     <= skid_d;
            skid_src_q <= skid_src_d;
        end
    end

    assign in_rdy   = rdy_q;
    assign out_vld  = out_vld_q;
    assign out_last = out_last_q;
    assign out_src  = out_src_q;
    assign out_data = out_data_q;

`ifdef OT_WRR_MUX_STATS_EN
    logic [CNT_WIDTH-1:0] stat_q [IN_CNT];
    logic [CNT_WIDTH-1:0] stat_d [IN_CNT];

    always_comb begin
        for (int i = 0; i < IN_CNT; i++) begin
            stat_d[i] = stat_q[i];
            if (out_vld_q && out_rdy && out_last_q &&
                out_src_q == SW'(i) && stat_q[i] != '1) begin
                stat_d[i] = stat_q[i] + 1'b1;
            end
            stat_pkt[i*CNT_WIDTH +: CNT_WIDTH] = stat_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < IN_CNT; i++) stat_q[i] <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end
`else
    logic [CNT_WIDTH-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule
